// File: rtl/serial_gf_inv_mult.sv
// serial_gf_inv_mult: bit-serial GF(2^8) multiply of LANES bytes by an
// AES InvMixColumns constant (0x0E/0x0B/0x0D/0x09), MSB plane first.
//
// Ports:
//   sys_clk_in, sys_reset_in : clock, synchronous active-high reset
//   start_in, factor_sel_in  : start an operation with a multiplier code
//   bitline_in, plane_valid_in, plane_ready_out : input plane handshake
//   product_out, plane_valid_out, plane_ready_in : output plane handshake
//   busy_out, done_out, err_out : status
//
// Optional: SERIAL_GF_INV_FWD_EN adds forward codes 1xx (0x02, 0x03,
// 0x01) and ties err_out low.
module serial_gf_inv_mult #(
    parameter int         LANES   = 8,
    parameter logic [7:0] GF_POLY = 8'h1B
) (
    input  logic             sys_clk_in,
    input  logic             sys_reset_in,
    input  logic             start_in,
    input  logic [2:0]       factor_sel_in,
    input  logic [LANES-1:0] bitline_in,
    input  logic             plane_valid_in,
    output logic             plane_ready_out,
    output logic [LANES-1:0] product_out,
    output logic             plane_valid_out,
    input  logic             plane_ready_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             err_out
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cnt_q;
    logic [7:0] coef_q;
    logic [7:0] acc_q [LANES];
    logic       err_q;

    logic       code_ok;
    logic [7:0] code_coef;
    logic       start_ok;
    logic       load_fire;
    logic       drain_fire;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Multiplier code decode
    always_comb begin
        code_ok   = 1'b1;
        code_coef = 8'h00;
        case (factor_sel_in)
            3'b000:  code_coef = 8'h0E;
            3'b001:  code_coef = 8'h0B;
            3'b010:  code_coef = 8'h0D;
            3'b011:  code_coef = 8'h09;
`ifdef SERIAL_GF_INV_FWD_EN
            3'b100:  code_coef = 8'h02;
            3'b101:  code_coef = 8'h03;
            default: code_coef = 8'h01;
`else
            default: code_ok   = 1'b0;
`endif
        endcase
    end

    assign start_ok   = (state_q == IDLE) && start_in && code_ok;
    assign load_fire  = (state_q == LOAD) && plane_valid_in;
    assign drain_fire = (state_q == DRAIN) && plane_ready_in;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_ok) state_d = LOAD;
            LOAD:  if (load_fire && cnt_q == 3'd7) state_d = DRAIN;
            DRAIN: if (drain_fire && cnt_q == 3'd7) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    // Control registers; one counter serves both LOAD and DRAIN and
    // wraps 7->0 on the transition between them.
    always_ff @(posedge sys_clk_in) begin
        if (sys_reset_in) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            coef_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                cnt_q  <= 3'd0;
                coef_q <= code_coef;
            end else if (load_fire || drain_fire) begin
                cnt_q <= cnt_q + 3'd1;
            end
`ifdef SERIAL_GF_INV_FWD_EN
            err_q <= 1'b0;
`else
            err_q <= (state_q == IDLE) && start_in && !code_ok;
`endif
        end
    end

    // Horner accumulation, MSB plane first: acc = acc*x + bit*C
    always_ff @(posedge sys_clk_in) begin
        if (sys_reset_in || start_ok) begin
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= 8'h00;
            end
        end else if (load_fire) begin
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= xtime(acc_q[i])
                          ^ (bitline_in[i] ? coef_q : 8'h00);
            end
        end
    end

    // Output plane k is bit 7-k of each accumulator; it only moves
    // when the counter moves, so it holds during back-pressure.
    always_comb begin
        product_out = '0;
        if (state_q == DRAIN) begin
            for (int i = 0; i < LANES; i++) begin
                product_out[i] = acc_q[i][3'd7 - cnt_q];
            end
        end
    end

    assign plane_ready_out = (state_q == LOAD);
    assign plane_valid_out = (state_q == DRAIN);
    assign busy_out        = (state_q != IDLE);
    assign done_out        = (state_q == DONE);
    assign err_out         = err_q;

endmodule

// File: tb/tb_serial_gf_inv_mult.sv
// tb_serial_gf_inv_mult: directed scoreboard bench for serial_gf_inv_mult.
// Expected product planes are queued at load time and popped on drain.
module tb_serial_gf_inv_mult;

    localparam int LANES = 8;

    logic             sys_clk_in = 1'b0;
    logic             sys_reset_in;
    logic             start_in;
    logic [2:0]       factor_sel_in;
    logic [LANES-1:0] bitline_in;
    logic             plane_valid_in;
    logic             plane_ready_out;
    logic [LANES-1:0] product_out;
    logic             plane_valid_out;
    logic             plane_ready_in;
    logic             busy_out;
    logic             done_out;
    logic             err_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [LANES-1:0] exp_q[$];
    logic [7:0]       lane_b [LANES];

    serial_gf_inv_mult #(.LANES(LANES), .GF_POLY(8'h1B)) dut (
        .sys_clk_in     (sys_clk_in),
        .sys_reset_in   (sys_reset_in),
        .start_in       (start_in),
        .factor_sel_in  (factor_sel_in),
        .bitline_in     (bitline_in),
        .plane_valid_in (plane_valid_in),
        .plane_ready_out(plane_ready_out),
        .product_out    (product_out),
        .plane_valid_out(plane_valid_out),
        .plane_ready_in (plane_ready_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .err_out        (err_out)
    );

    always #5 sys_clk_in = ~sys_clk_in;

    task automatic step();
        @(negedge sys_clk_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Shift-and-add GF(2^8) product, LSB of b first
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       hi;
        p = 8'h00;
        x = a;
        y = b;
        for (int j = 0; j < 8; j++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1B;
            y  = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] coef_of(input logic [2:0] c);
        case (c)
            3'b000:  return 8'h0E;
            3'b001:  return 8'h0B;
            3'b010:  return 8'h0D;
            3'b011:  return 8'h09;
            3'b100:  return 8'h02;
            3'b101:  return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    task automatic push_expected(input logic [2:0] code);
        logic [7:0]       prod [LANES];
        logic [LANES-1:0] pl;
        for (int i = 0; i < LANES; i++) begin
            prod[i] = gmul(lane_b[i], coef_of(code));
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < LANES; i++) begin
                pl[i] = prod[i][7-k];
            end
            exp_q.push_back(pl);
        end
    endtask

    function automatic logic [LANES-1:0] in_plane(input int p);
        logic [LANES-1:0] pl;
        for (int i = 0; i < LANES; i++) begin
            pl[i] = lane_b[i][7-p];
        end
        return pl;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] code,
                          input int gap_pct, input int bp_pct,
                          input bit chk_lat);
        int               cyc;
        int               tmo;
        logic [LANES-1:0] held;
        logic [LANES-1:0] e;
        start_in      = 1'b1;
        factor_sel_in = code;
        step();
        start_in = 1'b0;
        cyc = 1;
        chk({tag, "_ready"}, plane_ready_out, 1'b1);
        push_expected(code);
        for (int p = 0; p < 8; p++) begin
            bit sent;
            sent = 1'b0;
            while (!sent) begin
                bitline_in = in_plane(p);
                if ($urandom_range(0, 99) < gap_pct) begin
                    plane_valid_in = 1'b0;
                end else begin
                    plane_valid_in = 1'b1;
                    sent = 1'b1;
                end
                step();
                cyc++;
            end
        end
        plane_valid_in = 1'b0;
        bitline_in     = '0;
        tmo = 0;
        while (exp_q.size() > 0 && tmo < 200) begin
            tmo++;
            if (plane_valid_out !== 1'b1) begin
                plane_ready_in = 1'b0;
                step();
                cyc++;
            end else if ($urandom_range(0, 99) < bp_pct) begin
                plane_ready_in = 1'b0;
                held = product_out;
                step();
                cyc++;
                chk({tag, "_hold"}, product_out, held);
            end else begin
                plane_ready_in = 1'b1;
                e = exp_q.pop_front();
                chk({tag, "_plane"}, product_out, e);
                step();
                cyc++;
            end
        end
        plane_ready_in = 1'b0;
        if (exp_q.size() > 0) begin
            chk({tag, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        chk({tag, "_done"}, done_out, 1'b1);
        if (chk_lat) chk({tag, "_done_cycle"}, cyc, 17);
        step();
        chk({tag, "_done_pulse"}, done_out, 1'b0);
        chk({tag, "_idle"}, busy_out, 1'b0);
    endtask

    task automatic set_lanes(input logic [7:0] v);
        for (int i = 0; i < LANES; i++) lane_b[i] = v;
    endtask

    initial begin
        sys_reset_in   = 1'b1;
        start_in       = 1'b0;
        factor_sel_in  = 3'b000;
        bitline_in     = '0;
        plane_valid_in = 1'b0;
        plane_ready_in = 1'b0;
        set_lanes(8'h00);
        step();
        step();
        sys_reset_in = 1'b0;
        step();

        // Reset state
        chk("rst_ready", plane_ready_out, 1'b0);
        chk("rst_product", product_out, '0);
        chk("rst_pvalid", plane_valid_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_done", done_out, 1'b0);
        chk("rst_err", err_out, 1'b0);

        // plane_valid_in ignored while idle
        plane_valid_in = 1'b1;
        bitline_in     = '1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("idle_ready", plane_ready_out, 1'b0);
            chk("idle_busy", busy_out, 1'b0);
        end
        plane_valid_in = 1'b0;
        bitline_in     = '0;
        step();

        // Code 000 on three distinct lanes, no stalls
        set_lanes(8'h00);
        lane_b[0] = 8'h80;
        lane_b[1] = 8'hFF;
        lane_b[2] = 8'h01;
        run_op("c000", 3'b000, 0, 0, 1'b1);

        set_lanes(8'h00);
        lane_b[0] = 8'h80;
        run_op("c011", 3'b011, 0, 0, 1'b1);
        lane_b[0] = 8'hFF;
        run_op("c001", 3'b001, 0, 0, 1'b1);
        run_op("c010", 3'b010, 0, 0, 1'b1);

        // Gaps and back-pressure
        set_lanes(8'hFF);
        run_op("stall", 3'b010, 40, 40, 1'b0);
        for (int i = 0; i < LANES; i++) lane_b[i] = 8'($urandom);
        run_op("rnd", 3'($urandom_range(0, 3)), 30, 30, 1'b0);

        // Reset mid-LOAD after 4 planes
        set_lanes(8'h5A);
        start_in      = 1'b1;
        factor_sel_in = 3'b000;
        step();
        start_in = 1'b0;
        for (int p = 0; p < 4; p++) begin
            bitline_in     = in_plane(p);
            plane_valid_in = 1'b1;
            step();
        end
        plane_valid_in = 1'b0;
        sys_reset_in   = 1'b1;
        step();
        sys_reset_in = 1'b0;
        chk("mid_rst_busy", busy_out, 1'b0);
        chk("mid_rst_ready", plane_ready_out, 1'b0);
        chk("mid_rst_done", done_out, 1'b0);
        step();
        chk("mid_rst_done2", done_out, 1'b0);
        chk("mid_rst_err", err_out, 1'b0);
        set_lanes(8'h00);
        lane_b[0] = 8'h80;
        run_op("post_rst", 3'b011, 0, 0, 1'b1);

        // Forward codes
`ifdef SERIAL_GF_INV_FWD_EN
        lane_b[0] = 8'h57;
        run_op("c101", 3'b101, 0, 0, 1'b1);
        run_op("c100", 3'b100, 0, 0, 1'b1);
`else
        start_in      = 1'b1;
        factor_sel_in = 3'b101;
        step();
        start_in = 1'b0;
        chk("c101_err", err_out, 1'b1);
        chk("c101_busy", busy_out, 1'b0);
        step();
        chk("c101_err_pulse", err_out, 1'b0);
        chk("c101_busy2", busy_out, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
